// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared definitions for the block-transfer data memory:
//               controller state encoding, default parameter values and a
//               helper that sizes the latency counter.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEF_DATA_W      = 8;
  localparam int unsigned DEF_ADDR_W      = 8;
  localparam int unsigned DEF_BLOCK_WORDS = 4;
  localparam int unsigned DEF_LATENCY     = 5;

  // Counter width: $clog2(latency), never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned latency);
    int unsigned w;
    w = $clog2(latency);
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_latency_counter.sv
`default_nettype none
// ============================================================================
// Module      : mem_latency_counter
// Description : Down-counter that times one memory access. A load presets
//               it to LATENCY-1; it then steps down while dec is high and
//               flags zero when the access is due to complete.
// Ports       : clock  - rising-edge clock
//               reset  - asynchronous active-high reset (count -> 0)
//               load   - preset count to LATENCY-1
//               dec    - decrement enable
//               zero   - count equals zero
// Revision    : 1.0 - initial release
// ============================================================================
module mem_latency_counter
  import mem_pkg::*;
#(
  parameter int unsigned LATENCY = DEF_LATENCY,
  parameter int unsigned CNT_W   = cnt_width(LATENCY)
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = LOAD_VAL;
    end else if (dec) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/param_data_memory.sv
`default_nettype none
// ============================================================================
// Module      : param_data_memory
// Description : Word-organised data memory accessed in blocks of
//               BLOCK_WORDS words. Each accepted read or write completes a
//               fixed LATENCY edges after acceptance; a simultaneous
//               read+write request is refused and flagged on err.
// Ports       : clock     - rising-edge clock
//               reset     - asynchronous active-high reset (clears memory)
//               read      - block read request
//               write     - block write request
//               address   - block address
//               writedata - block to write, word i at [i*DATA_W +: DATA_W]
//               readdata  - last block read
//               busywait  - access in progress
//               err       - sticky illegal-request flag
// Revision    : 1.0 - initial release
// ============================================================================
module param_data_memory
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned BLOCK_WORDS = DEF_BLOCK_WORDS,
  parameter int unsigned LATENCY     = DEF_LATENCY
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   read,
  input  logic                                   write,
  input  logic [ADDR_W-$clog2(BLOCK_WORDS)-1:0]  address,
  input  logic [DATA_W*BLOCK_WORDS-1:0]          writedata,
  output logic [DATA_W*BLOCK_WORDS-1:0]          readdata,
  output logic                                   busywait,
  output logic                                   err
);

  localparam int unsigned OFFS_W  = $clog2(BLOCK_WORDS);
  localparam int unsigned BLK_W   = ADDR_W - OFFS_W;
  localparam int unsigned DEPTH   = 2 ** ADDR_W;
  localparam int unsigned BLOCK_W = DATA_W * BLOCK_WORDS;

  state_t               state_q, state_d;
  logic                 op_write_q, op_write_d;
  logic [BLK_W-1:0]     addr_q, addr_d;
  logic [BLOCK_W-1:0]   wdata_q, wdata_d;
  logic [BLOCK_W-1:0]   rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic [DATA_W-1:0]    mem_q [DEPTH];
  logic [DATA_W-1:0]    mem_d [DEPTH];

  logic                 cnt_load;
  logic                 cnt_dec;
  logic                 cnt_zero;
  logic                 wr_done;
  logic                 busy_raw;
  logic [ADDR_W-1:0]    base_addr;

  mem_latency_counter #(
    .LATENCY (LATENCY)
  ) u_latency_counter (
    .clock (clock),
    .reset (reset),
    .load  (cnt_load),
    .dec   (cnt_dec),
    .zero  (cnt_zero)
  );

  // First word address of the latched block.
  assign base_addr = ADDR_W'(addr_q) << OFFS_W;

  always_comb begin
    state_d    = state_q;
    op_write_d = op_write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    wr_done    = 1'b0;
    busy_raw   = 1'b0;
    case (state_q)
      IDLE: begin
        if (read && write) begin
          err_d = 1'b1;
        end else if (read ^ write) begin
          busy_raw   = 1'b1;
          cnt_load   = 1'b1;
          op_write_d = write;
          addr_d     = address;
          wdata_d    = writedata;
          err_d      = 1'b0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        busy_raw = 1'b1;
        if (cnt_zero) begin
          state_d = DONE;
          if (op_write_q) begin
            wr_done = 1'b1;
          end else begin
            for (int i = 0; i < BLOCK_WORDS; i++) begin
              rdata_d[i*DATA_W +: DATA_W] = mem_q[base_addr + ADDR_W'(i)];
            end
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      DONE: begin
        // Inputs are deliberately ignored here so a held request is only
        // re-accepted once the controller is back in IDLE.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    mem_d = mem_q;
    if (wr_done) begin
      for (int i = 0; i < BLOCK_WORDS; i++) begin
        mem_d[base_addr + ADDR_W'(i)] = wdata_q[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_write_q <= op_write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  for (genvar w = 0; w < DEPTH; w++) begin : g_mem_word
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        mem_q[w] <= '0;
      end else begin
        mem_q[w] <= mem_d[w];
      end
    end
  end

  // Reset forces busywait low even if a request is already presented.
  assign busywait = busy_raw & ~reset;
  assign readdata = rdata_q;
  assign err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_param_data_memory.sv
`default_nettype none
// ============================================================================
// Module      : tb_param_data_memory
// Description : Self-checking bench for param_data_memory. A default
//               instance (LATENCY=5) and a LATENCY=1, ADDR_W=10 instance are
//               compared against a word-array reference model.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_param_data_memory;

  localparam int L0 = 5;

  logic        clock = 1'b0;
  logic        reset = 1'b0;

  logic        read = 1'b0, write = 1'b0;
  logic [5:0]  address = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        busywait, err;

  logic        read1 = 1'b0, write1 = 1'b0;
  logic [7:0]  address1 = '0;
  logic [31:0] writedata1 = '0;
  logic [31:0] readdata1;
  logic        busywait1, err1;

  int passes = 0;
  int checks = 0;
  int fails  = 0;

  logic [7:0]  m_mem [256];
  logic [31:0] m_rd;

  always #5 clock = ~clock;

  param_data_memory dut (
    .clock     (clock),
    .reset     (reset),
    .read      (read),
    .write     (write),
    .address   (address),
    .writedata (writedata),
    .readdata  (readdata),
    .busywait  (busywait),
    .err       (err)
  );

  param_data_memory #(
    .DATA_W      (8),
    .ADDR_W      (10),
    .BLOCK_WORDS (4),
    .LATENCY     (1)
  ) dut1 (
    .clock     (clock),
    .reset     (reset),
    .read      (read1),
    .write     (write1),
    .address   (address1),
    .writedata (writedata1),
    .readdata  (readdata1),
    .busywait  (busywait1),
    .err       (err1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_block(input int blk);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = m_mem[blk*4 + i];
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
    m_rd = '0;
  endtask

  // One isolated access on the default instance, checked edge by edge.
  task automatic access(input bit wr, input int blk, input logic [31:0] wd);
    @(negedge clock);
    read = !wr; write = wr; address = 6'(blk); writedata = wd;
    #1 check("bw_request", busywait, 1);
    @(posedge clock); #1;
    check("bw_accepted", busywait, 1);
    check("err_after_accept", err, 0);
    @(negedge clock);
    read = 0; write = 0;
    for (int k = 1; k < L0; k++) begin
      @(posedge clock); #1;
      check("bw_busy", busywait, 1);
    end
    @(posedge clock); #1;
    check("bw_done", busywait, 0);
    if (wr) begin
      for (int i = 0; i < 4; i++) m_mem[blk*4 + i] = wd[i*8 +: 8];
    end else begin
      m_rd = model_block(blk);
    end
    check(wr ? "rd_hold_on_write" : "rd_data", readdata, m_rd);
    @(posedge clock); #1;
    check("bw_idle", busywait, 0);
  endtask

  initial begin
    logic [31:0] d;
    int          b;
    bit          w;

    model_clear();

    // Reset state
    reset = 1'b1;
    #1;
    check("reset_rd", readdata, 0);
    check("reset_bw", busywait, 0);
    check("reset_err", err, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Write then read block 3, words 12..15
    access(1, 3, 32'hDDCCBBAA);
    check("word12", {24'd0, m_mem[12]}, 8'hAA);
    access(0, 3, 32'h0);
    check("blk3_read", readdata, 32'hDDCCBBAA);

    // Randomised traffic over a few blocks
    for (int n = 0; n < 6; n++) access(1, n, $urandom);
    for (int n = 0; n < 14; n++) begin
      b = $urandom_range(0, 7);
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      access(w, b, d);
    end

    // Input changes while BUSY are ignored
    d = $urandom;
    access(1, 7, d);
    access(1, 1, ~d);
    @(negedge clock);
    read = 1; address = 6'd1;
    @(posedge clock);
    @(negedge clock);
    repeat (2) @(posedge clock);
    @(negedge clock);
    read = 0; write = 1; address = 6'd7; writedata = ~writedata;
    repeat (L0 - 2) @(posedge clock);
    #1;
    m_rd = model_block(1);
    check("busy_change_rd", readdata, m_rd);
    check("busy_change_bw", busywait, 0);
    @(negedge clock);
    write = 0;
    @(posedge clock);
    access(0, 7, 32'h0);
    check("blk7_unchanged", readdata, d);

    // Illegal read+write in IDLE
    @(negedge clock);
    read = 1; write = 1;
    #1 check("illegal_bw_pre", busywait, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      check("illegal_bw", busywait, 0);
      check("illegal_err", err, 1);
    end
    @(negedge clock);
    read = 0; write = 0;
    @(posedge clock); #1;
    check("err_sticky", err, 1);
    check("illegal_no_rd", readdata, m_rd);
    access(1, 9, $urandom);

    // Reset in the second BUSY cycle aborts the write
    @(negedge clock);
    write = 1; address = 6'd0; writedata = 32'h11223344;
    @(posedge clock);
    @(negedge clock);
    write = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    model_clear();
    check("midreset_bw", busywait, 0);
    check("midreset_rd", readdata, 0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    access(0, 0, 32'h0);
    check("blk0_after_reset", readdata, 0);
    access(0, 3, 32'h0);
    check("blk3_after_reset", readdata, 0);

    // Back-to-back reads with read held high
    access(1, 5, $urandom);
    access(1, 6, $urandom);
    @(negedge clock);
    read = 1; address = 6'd5;
    @(posedge clock); #1;
    check("b2b_bw1", busywait, 1);
    repeat (L0) @(posedge clock);
    #1;
    m_rd = model_block(5);
    check("b2b_done_bw", busywait, 0);
    check("b2b_rd1", readdata, m_rd);
    @(negedge clock);
    address = 6'd6;
    @(posedge clock); #1;
    check("b2b_idle_bw", busywait, 1);
    check("b2b_hold_rd", readdata, m_rd);
    @(posedge clock);
    @(negedge clock);
    read = 0;
    for (int k = 1; k < L0; k++) begin
      @(posedge clock); #1;
      check("b2b_busy2", busywait, 1);
    end
    @(posedge clock); #1;
    m_rd = model_block(6);
    check("b2b_done2_bw", busywait, 0);
    check("b2b_rd2", readdata, m_rd);
    @(posedge clock);

    // LATENCY=1 instance, block 255
    d = $urandom;
    @(negedge clock);
    write1 = 1; address1 = 8'd255; writedata1 = d;
    @(posedge clock); #1;
    check("l1_wr_bw", busywait1, 1);
    @(negedge clock);
    write1 = 0;
    @(posedge clock); #1;
    check("l1_wr_done_bw", busywait1, 0);
    @(posedge clock);
    @(negedge clock);
    read1 = 1;
    @(posedge clock); #1;
    check("l1_rd_not_early", readdata1, 0);
    @(negedge clock);
    read1 = 0;
    @(posedge clock); #1;
    check("l1_rd_data", readdata1, d);
    check("l1_rd_bw", busywait1, 0);
    check("l1_err", err1, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/param_data_memory.md
PARAM_DATA_MEMORY -- requirements
Module: param_data_memory

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DATA_W, 8, bits per word.
- ADDR_W, 8, word-address width; depth = 2**ADDR_W words.
- BLOCK_WORDS, 4, words per transfer; power of two, at least 1.
- LATENCY, 5, clock cycles from acceptance to completion; at least 1.

REQ-002 The block SHALL have these ports (name, direction, width, meaning), clock and reset first:
- clock, in, 1, rising-edge clock.
- reset, in, 1, asynchronous, active-high.
- read, in, 1, block read request.
- write, in, 1, block write request.
- address, in, ADDR_W-log2(BLOCK_WORDS), block address.
- writedata, in, DATA_W*BLOCK_WORDS, write block.
- readdata, out, DATA_W*BLOCK_WORDS, read block.
- busywait, out, 1, access in progress.
- err, out, 1, illegal read+write request seen.

Function
REQ-003 Word i of a block SHALL map to word address address*BLOCK_WORDS+i and to data bits [i*DATA_W +: DATA_W].
REQ-004 The state machine SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-005 In IDLE, read XOR write at a rising edge SHALL accept the request:
- latch read/write, address and writedata;
- load the cycle counter with LATENCY-1;
- move to BUSY.
REQ-006 busywait SHALL be combinational:
- high when state is IDLE and (read XOR write) is 1;
- high whenever state is BUSY;
- low in DONE and otherwise.
REQ-007 In BUSY the counter SHALL decrement on each edge. At the edge where the counter equals 0, the latched operation SHALL complete and the state SHALL move to DONE.
REQ-008 For an accepted request, completion SHALL occur exactly LATENCY rising edges after the accepting edge.
REQ-009 On read completion, all BLOCK_WORDS words SHALL be registered into readdata at the completion edge.
REQ-010 readdata SHALL hold its value until the next read completes or reset; writes SHALL NOT change readdata.
REQ-011 On write completion, all BLOCK_WORDS words SHALL be stored at the completion edge; no memory word SHALL change at any other edge.
REQ-012 Changes to read, write, address or writedata while in BUSY or DONE SHALL be ignored.
REQ-013 DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-014 A request still asserted in the DONE cycle SHALL NOT be accepted. If it is still asserted in the following IDLE cycle, it SHALL be accepted as a new access.
REQ-015 In IDLE, read AND write at an edge SHALL NOT start an access:
- state stays IDLE;
- busywait stays low;
- err is set to 1.
REQ-016 err SHALL be sticky until the next accepted request (cleared at the accepting edge) or reset.
REQ-017 The counter SHALL be $clog2(LATENCY) bits wide, minimum 1 bit.
REQ-018 With LATENCY=1, the accepting edge SHALL be followed by completion at the very next edge.

Reset
REQ-019 Assertion of reset SHALL immediately, without waiting for a clock edge:
- set the state to IDLE and the counter to 0;
- set readdata to 0 and err to 0;
- set every memory word to 0.
REQ-020 Reset during BUSY SHALL abort the access: no memory write and no readdata update.
REQ-021 busywait SHALL be low during reset and in the first cycle after reset unless a request is present per REQ-006.
REQ-022 While reset is high, all clock edges SHALL be ignored.

Structure
REQ-023 The state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) and the default parameter values SHALL reside in the shared package mem_pkg.
REQ-024 The cycle counter SHALL be a separate sub-module named mem_latency_counter with:
- input load, loaded with value LATENCY-1;
- decrement enable;
- zero-flag output.
REQ-025 The memory array SHALL be one array of DATA_W-bit words with depth 2**ADDR_W; no vendor RAM macros SHALL be used.

Verification (DATA_W=8, ADDR_W=8, BLOCK_WORDS=4, LATENCY=5)
REQ-026 Write then read, 32'hDDCCBBAA at block 3 -> words 12..15 equal AA, BB, CC, DD. A read of block 3 returns readdata=32'hDDCCBBAA at exactly the 5th edge after acceptance, with busywait low from that edge on.
REQ-027 Busy-time stimulus changes, read block 1 accepted then address changed to 7 and writedata toggled while BUSY -> readdata equals block 1 contents and block 7 is unchanged.
REQ-028 Illegal request, read=write=1 in IDLE for 3 cycles -> busywait stays 0, err=1, no access. A subsequent write=1 clears err at its accepting edge.
REQ-029 Reset mid-access, write 32'h11223344 to block 0 with reset pulsed at cycle 2 of BUSY -> state IDLE, busywait 0 and block 0 reads 0.
REQ-030 Back-to-back reads, read held high across completion -> one DONE cycle with busywait=0, then a second access is accepted and completes LATENCY edges later.
REQ-031 LATENCY=1 variant, read block 255 -> data is valid one edge after acceptance.
